// File: rtl/mem_arb_pkg.sv
// Shared widths, FSM state encoding and the latched memory command for the
// instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam int unsigned AW   = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  // Request held on the memory side for the whole transaction
  typedef struct packed {
    logic            we;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-facing fetch/data ports plus the single shared memory port.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic            halt;
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic [ILEN-1:0] if_rdata;
  logic            if_valid;
  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [XLEN-1:0] d_rdata;
  logic            d_valid;
  logic            m_req;
  logic            m_we;
  logic [AW-1:0]   m_addr;
  logic [XLEN-1:0] m_wdata;
  logic [XLEN-1:0] m_rdata;
  logic            m_ready;
  logic            stall_if;
  logic            stall_mem;
  logic            bus_err;

  // Arbiter side
  modport slave (
    input  halt, if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    output if_rdata, if_valid, d_rdata, d_valid, m_req, m_we, m_addr, m_wdata,
           stall_if, stall_mem, bus_err
  );

  // Pipeline + memory environment side
  modport master (
    output halt, if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    input  if_rdata, if_valid, d_rdata, d_valid, m_req, m_we, m_addr, m_wdata,
           stall_if, stall_mem, bus_err
  );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Counts consecutive BUSY cycles; expired flags the TIMEOUT-th one.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM-stage requests onto one memory port, data first,
// with an anti-starvation override for fetch and a BUSY watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e      state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  mem_cmd_t        cmd_q, cmd_d;
  logic            m_req_q, m_req_d;
  logic            if_valid_q, if_valid_d;
  logic            d_valid_q, d_valid_d;
  logic            bus_err_q, bus_err_d;
  logic [ILEN-1:0] if_rdata_q, if_rdata_d;
  logic [XLEN-1:0] d_rdata_q, d_rdata_d;
  logic            grant_i, grant_d, starve_hit;
  logic            wd_expired;

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == IDLE),
    .enable (state_q != IDLE),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Grant decision, completion handling and next values of all registered outputs
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    cmd_d      = cmd_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    bus_err_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    starve_hit = (starve_q >= STARVE_MAX);

    case (state_q)
      IDLE: begin
        if (bus.if_req && !bus.halt && (!bus.d_req || starve_hit)) grant_i = 1'b1;
        else if (bus.d_req)                                         grant_d = 1'b1;
        if (grant_i) begin
          state_d    = BUSY_I;
          cmd_d.we   = 1'b0;
          cmd_d.addr = bus.if_addr;
        end else if (grant_d) begin
          state_d = BUSY_D;
          cmd_d   = '{we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata};
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.m_ready || wd_expired) begin
          state_d   = IDLE;
          bus_err_d = !bus.m_ready;
          if (state_q == BUSY_I) begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.m_ready ? bus.m_rdata[ILEN-1:0] : '0;
          end else begin
            d_valid_d = 1'b1;
            // stores never disturb the last load result
            if (!cmd_q.we) d_rdata_d = bus.m_ready ? bus.m_rdata : '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_i || !bus.if_req)   starve_d = '0;
    else if (grant_d && !starve_hit) starve_d = starve_q + SW'(1);

    m_req_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q   <= '0;
      cmd_q      <= '0;
      m_req_q    <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      starve_q   <= starve_d;
      cmd_q      <= cmd_d;
      m_req_q    <= m_req_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      bus_err_q  <= bus_err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.m_req     = m_req_q;
  assign bus.m_we      = cmd_q.we;
  assign bus.m_addr    = cmd_q.addr;
  assign bus.m_wdata   = cmd_q.wdata;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.stall_if  = bus.if_req & ~if_valid_q;
  assign bus.stall_mem = bus.d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned TIMEOUT      = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: one outstanding transaction at most, plus starvation count
  bit          md_busy;
  bit          md_kind_d;
  int          md_age;
  int          md_starve;
  logic        e_m_req, e_m_we, e_if_valid, e_d_valid, e_bus_err;
  logic [31:0] e_m_addr, e_if_rdata;
  logic [63:0] e_m_wdata, e_d_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 64'(act), 64'(exp));
  endtask

  task automatic model_step();
    bit          gi, gd;
    logic [63:0] rd;
    gi = 1'b0;
    gd = 1'b0;
    if (rst) begin
      md_busy = 1'b0; md_age = 0; md_starve = 0;
      e_m_req = 1'b0; e_m_we = 1'b0; e_if_valid = 1'b0; e_d_valid = 1'b0; e_bus_err = 1'b0;
      e_m_addr = '0; e_if_rdata = '0; e_m_wdata = '0; e_d_rdata = '0;
      return;
    end
    e_if_valid = 1'b0;
    e_d_valid  = 1'b0;
    e_bus_err  = 1'b0;
    if (md_busy) begin
      md_age++;
      if (bus.m_ready || md_age >= int'(TIMEOUT)) begin
        rd = bus.m_ready ? bus.m_rdata : 64'd0;
        e_bus_err = !bus.m_ready;
        if (md_kind_d) begin
          e_d_valid = 1'b1;
          if (!e_m_we) e_d_rdata = rd;
        end else begin
          e_if_valid = 1'b1;
          e_if_rdata = rd[31:0];
        end
        md_busy = 1'b0;
      end
    end else begin
      gi = bus.if_req && !bus.halt && (!bus.d_req || md_starve >= int'(STARVE_LIMIT));
      gd = bus.d_req && !gi;
      if (gi) begin
        md_busy = 1'b1; md_kind_d = 1'b0; md_age = 0;
        e_m_addr = bus.if_addr; e_m_we = 1'b0;
      end else if (gd) begin
        md_busy = 1'b1; md_kind_d = 1'b1; md_age = 0;
        e_m_addr = bus.d_addr; e_m_we = bus.d_we; e_m_wdata = bus.d_wdata;
      end
    end
    if (gi || !bus.if_req) md_starve = 0;
    else if (gd)           md_starve = (md_starve + 1 > int'(STARVE_LIMIT)) ? int'(STARVE_LIMIT) : md_starve + 1;
    e_m_req = md_busy;
  endtask

  // Compare process: registered outputs at +1, stalls after inputs settle at +3
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk1("m_req", bus.m_req, e_m_req);
      chk1("m_we", bus.m_we, e_m_we);
      chk("m_addr", 64'(bus.m_addr), 64'(e_m_addr));
      chk("m_wdata", bus.m_wdata, e_m_wdata);
      chk1("if_valid", bus.if_valid, e_if_valid);
      chk("if_rdata", 64'(bus.if_rdata), 64'(e_if_rdata));
      chk1("d_valid", bus.d_valid, e_d_valid);
      chk("d_rdata", bus.d_rdata, e_d_rdata);
      chk1("bus_err", bus.bus_err, e_bus_err);
      #2;
      chk1("stall_if", bus.stall_if, bus.if_req & ~e_if_valid);
      chk1("stall_mem", bus.stall_mem, bus.d_req & ~e_d_valid);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int ngr;
    int waited;
    bit found;
    rst = 1'b1;
    bus.halt = 1'b0; bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_ready = 1'b0; bus.m_rdata = '0;
    tick(); tick();
    chk1("rst_m_req", bus.m_req, 1'b0);
    chk1("rst_valids", bus.if_valid | bus.d_valid | bus.bus_err, 1'b0);
    chk("rst_if_rdata", 64'(bus.if_rdata), 64'd0);
    chk("rst_d_rdata", bus.d_rdata, 64'd0);
    chk("rst_m_addr", 64'(bus.m_addr), 64'd0);
    chk("rst_m_wdata", bus.m_wdata, 64'd0);
    rst = 1'b0;

    // zero-wait fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h40; bus.m_ready = 1'b1; bus.m_rdata = 64'h0050_0093;
    tick();
    chk1("zw_m_req_c1", bus.m_req, 1'b1);
    chk("zw_m_addr", 64'(bus.m_addr), 64'h40);
    tick();
    chk1("zw_if_valid_c2", bus.if_valid, 1'b1);
    chk("zw_if_rdata", 64'(bus.if_rdata), 64'h0050_0093);
    bus.if_req = 1'b0;
    tick();

    // simultaneous requests: data first, fetch stalled until its own valid
    bus.m_ready = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h80;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
    tick();
    chk("both_first_addr", 64'(bus.m_addr), 64'h100);
    chk1("both_stall_if", bus.stall_if, 1'b1);
    bus.m_ready = 1'b1; bus.m_rdata = 64'h1122_3344_5566_7788;
    tick();
    chk1("both_d_valid", bus.d_valid, 1'b1);
    chk("both_d_rdata", bus.d_rdata, 64'h1122_3344_5566_7788);
    chk1("both_stall_if_held", bus.stall_if, 1'b1);
    bus.d_req = 1'b0;
    tick();
    chk("both_second_addr", 64'(bus.m_addr), 64'h80);
    tick();
    chk1("both_if_valid", bus.if_valid, 1'b1);
    chk("both_if_rdata", 64'(bus.if_rdata), 64'h5566_7788);
    bus.if_req = 1'b0;
    tick();

    // starvation: continuous loads with fetch pending, 5th grant goes to IF
    bus.m_ready = 1'b1; bus.m_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300;
    ngr = 0; found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (bus.m_req && bus.m_addr == 32'h200) found = 1'b1;
      else if (bus.m_req) ngr++;
    end
    chk1("starve_if_granted", found, 1'b1);
    chk("starve_data_grants", 64'(ngr), 64'd4);
    bus.d_req = 1'b0;
    tick();
    bus.if_req = 1'b0;
    tick();

    // watchdog abort of a fetch
    bus.m_ready = 1'b0; bus.m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.if_req = 1'b1; bus.if_addr = 32'h500;
    tick();
    waited = 0;
    while (!bus.if_valid && waited < 200) begin
      tick();
      waited++;
    end
    chk("to_latency", 64'(waited), 64'd64);
    chk1("to_bus_err", bus.bus_err, 1'b1);
    chk("to_if_rdata", 64'(bus.if_rdata), 64'd0);
    bus.if_req = 1'b0;
    tick();
    chk1("to_bus_err_pulse", bus.bus_err, 1'b0);

    // halt blocks fetch; store leaves load data alone; m_ready in IDLE ignored
    bus.halt = 1'b1; bus.if_req = 1'b1; bus.if_addr = 32'h600; bus.m_ready = 1'b1;
    repeat (3) begin
      tick();
      chk1("halt_no_m_req", bus.m_req, 1'b0);
    end
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h700; bus.d_wdata = 64'hDEAD;
    bus.m_ready = 1'b0;
    tick();
    chk1("st_m_we", bus.m_we, 1'b1);
    chk("st_m_wdata", bus.m_wdata, 64'hDEAD);
    bus.m_ready = 1'b1; bus.m_rdata = 64'h0BAD;
    tick();
    chk1("st_d_valid", bus.d_valid, 1'b1);
    chk("st_d_rdata_kept", bus.d_rdata, 64'hA5A5_A5A5_A5A5_A5A5);
    bus.d_req = 1'b0;
    tick();

    // halt rising during a fetch does not abort it
    bus.halt = 1'b0; bus.m_ready = 1'b0;
    tick();
    chk("hb_m_addr", 64'(bus.m_addr), 64'h600);
    bus.halt = 1'b1;
    tick();
    bus.m_ready = 1'b1; bus.m_rdata = 64'h1234_5678;
    tick();
    chk1("hb_if_valid", bus.if_valid, 1'b1);
    chk("hb_if_rdata", 64'(bus.if_rdata), 64'h1234_5678);
    bus.if_req = 1'b0; bus.halt = 1'b0;
    tick();

    // reset during a data transaction
    bus.m_ready = 1'b0; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h800;
    tick();
    chk1("rb_m_req", bus.m_req, 1'b1);
    rst = 1'b1;
    tick();
    chk1("rb_m_req_dropped", bus.m_req, 1'b0);
    rst = 1'b0; bus.d_req = 1'b0; bus.m_ready = 1'b1;
    repeat (3) begin
      tick();
      chk1("rb_no_d_valid", bus.d_valid, 1'b0);
    end

    // randomized traffic; requesters hold until their valid, memory sometimes hangs
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!bus.if_req || e_if_valid) begin
        bus.if_req  = ($urandom_range(0, 2) != 0);
        bus.if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!bus.d_req || e_d_valid) begin
        bus.d_req   = ($urandom_range(0, 2) != 0);
        bus.d_we    = ($urandom_range(0, 1) == 1);
        bus.d_addr  = $urandom;
        bus.d_wdata = {$urandom, $urandom};
      end
      bus.halt    = ($urandom_range(0, 9) == 0);
      bus.m_ready = ((cyc % 700) >= 70) && ($urandom_range(0, 9) < 4);
      bus.m_rdata = {$urandom, $urandom};
      tick();
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive data grants while if_req is pending.
REQ-002 Parameter TIMEOUT, default 64: max BUSY cycles awaiting m_ready before abort.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 halt  in  1  pipeline halted; block new instruction grants.
REQ-006 if_req  in  1  instruction fetch request; held until if_valid.
REQ-007 if_addr  in  32  fetch address (pc).
REQ-008 if_rdata  out  32  fetched instruction; updated only on if_valid.
REQ-009 if_valid  out  1  one-cycle completion pulse for fetch.
REQ-010 d_req  in  1  MEM-stage data request; held until d_valid.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_addr  in  32  data address.
REQ-013 d_wdata  in  64  store data.
REQ-014 d_rdata  out  64  load data; updated only on a completing load.
REQ-015 d_valid  out  1  one-cycle completion pulse for data.
REQ-016 m_req, m_we  out  1 each  memory request and write enable.
REQ-017 m_addr  out  32; m_wdata  out  64: latched request address and data.
REQ-018 m_rdata  in  64; m_ready  in  1: memory read data; one-cycle completion.
REQ-019 stall_if, stall_mem  out  1 each  stall IF / MEM stage.
REQ-020 bus_err  out  1  one-cycle pulse coinciding with a timeout-aborted valid.

Function
REQ-021 FSM states IDLE, BUSY_I, BUSY_D; the FSM SHALL sit in IDLE after reset.
REQ-022 In IDLE with d_req=1: latch d_addr/d_we/d_wdata, go BUSY_D.
REQ-023 In IDLE with only if_req=1 and halt=0: latch if_addr, go BUSY_I.
REQ-024 Priority data > instruction, except: starve_cnt >= STARVE_LIMIT and if_req=1 and halt=0 SHALL grant IF.
REQ-025 starve_cnt: increments on each data grant while if_req=1; clears on any IF grant or when if_req=0; saturates at STARVE_LIMIT.
REQ-026 m_req, m_addr, m_we, m_wdata SHALL be driven from registers; m_req=1 exactly while in BUSY_I/BUSY_D.
REQ-027 For instruction fetch, m_we=0 and m_rdata[31:0] SHALL be returned on if_rdata.
REQ-028 Posedge in BUSY_x with m_ready=1: capture read data, pulse x_valid next cycle, return to IDLE.
REQ-029 Zero-wait latency: req sampled at edge 0, m_req high cycle 1, valid high cycle 2.
REQ-030 A new request SHALL be accepted in the same cycle x_valid is high, giving back-to-back throughput of one transaction per 2 cycles.
REQ-031 Store completion pulses d_valid and SHALL leave d_rdata unchanged.
REQ-032 A watchdog counts BUSY cycles; on reaching TIMEOUT without m_ready, return to IDLE and pulse x_valid and bus_err with rdata=0.
REQ-033 stall_if = if_req & ~if_valid; stall_mem = d_req & ~d_valid (combinational from registered valids).
REQ-034 halt rising during BUSY_I SHALL NOT abort the fetch; it completes normally.
REQ-035 m_ready outside BUSY SHALL be ignored.

Reset
REQ-036 On rst, state=IDLE, starve_cnt=0, and watchdog=0.
REQ-037 On rst, m_req, m_we, if_valid, d_valid, and bus_err SHALL be 0.
REQ-038 On rst, if_rdata, d_rdata, m_addr, and m_wdata SHALL be 0.
REQ-039 Reset mid-transaction SHALL drop m_req the following cycle and SHALL emit no valid for the aborted request.

Structure
REQ-040 Package mem_arb_pkg SHALL hold the state enum and widths XLEN=64, ILEN=32, AW=32.
REQ-041 The watchdog SHALL be sub-module mem_arb_watchdog (clear, enable, TIMEOUT, expired).

Verification
REQ-042 Zero-wait fetch: if_req=1, if_addr=0x40, m_rdata=0x00500093, m_ready asserted with m_req -> if_valid at cycle 2, if_rdata=0x00500093.
REQ-043 Simultaneous if_req and d_req (load, addr 0x100) -> BUSY_D first, then BUSY_I; stall_if high until its if_valid.
REQ-044 Continuous d_req with if_req pending, STARVE_LIMIT=4 -> 5th grant goes to IF.
REQ-045 m_ready never asserted, TIMEOUT=64 -> valid+bus_err pulse 64 cycles after BUSY entry, rdata=0.
REQ-046 halt=1 with if_req only -> no m_req; store d_req, d_wdata=0xDEAD -> m_we=1, m_wdata=0xDEAD, d_rdata unchanged.
REQ-047 rst asserted during BUSY_D -> m_req=0 next cycle, no d_valid, IDLE.
